// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register family: default word width,
// occupancy codes and the skid register state encoding.
package pipe_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // State bits are {skid valid, main valid}, so each bit doubles as a valid flag.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } skidState_e;

    function automatic logic [1:0] occOf(input skidState_e s);
        logic [1:0] occ;
        occ = OCC_EMPTY;
        case (s)
            EMPTY:   occ = OCC_EMPTY;
            ONE:     occ = OCC_ONE;
            TWO:     occ = OCC_TWO;
            default: occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/regn.sv
// Enable register with synchronous clear to a parameterised reset value.
module regn
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = WORD_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (clr) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_register.sv
// Ready/valid pipeline register with a one-entry skid buffer so that in_ready
// can come straight from a flop while still sustaining one word per cycle.
module skid_register
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = WORD_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             ctrl_flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    skidState_e state;
    skidState_e nextState;

    logic             mainV;
    logic             skidV;
    logic             accept;
    logic             consume;
    logic             mainLoad;
    logic             mainFromSkid;
    logic             skidLoad;
    logic             mainEn;
    logic             skidEn;
    logic [WIDTH-1:0] mainD;
    logic [WIDTH-1:0] mainData;
    logic [WIDTH-1:0] skidData;

    assign mainV   = state[0];
    assign skidV   = state[1];
    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // clr wins over flush; both return to EMPTY but only clr touches the data.
    always_ff @(posedge clock) begin
        if (clr) begin
            state <= EMPTY;
        end else if (ctrl_flush) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        mainLoad     = 1'b0;
        mainFromSkid = 1'b0;
        skidLoad     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    nextState = ONE;
                    mainLoad  = 1'b1;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    mainLoad = 1'b1;
                end else if (accept) begin
                    nextState = TWO;
                    skidLoad  = 1'b1;
                end else if (consume) begin
                    nextState = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    nextState    = ONE;
                    mainLoad     = 1'b1;
                    mainFromSkid = 1'b1;
                end
            end
            default: begin
                nextState = EMPTY;
            end
        endcase
    end

    // A flushed cycle must leave both data registers untouched.
    assign mainEn = mainLoad && !ctrl_flush;
    assign skidEn = skidLoad && !ctrl_flush;
    assign mainD  = mainFromSkid ? skidData : in_data;

    regn #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) mainReg (
        .clock (clock),
        .clr   (clr),
        .en    (mainEn),
        .d     (mainD),
        .q     (mainData)
    );

    regn #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) skidReg (
        .clock (clock),
        .clr   (clr),
        .en    (skidEn),
        .d     (in_data),
        .q     (skidData)
    );

    assign in_ready  = !skidV;
    assign out_valid = mainV;
    assign out_data  = mainData;
    assign occupancy = occOf(state);

endmodule

// File: tb/tb_skid_register.sv
// Bench for skid_register: directed scenarios on a 32-bit instance and a
// randomised run on an 8-bit instance against a queue-based reference.
module tb_skid_register;

    logic        clock;

    logic        clrA;
    logic        ctrlFlushA;
    logic        inValidA;
    logic        inReadyA;
    logic [31:0] inDataA;
    logic        outValidA;
    logic        outReadyA;
    logic [31:0] outDataA;
    logic [1:0]  occupancyA;

    logic        clrB;
    logic        ctrlFlushB;
    logic        inValidB;
    logic        inReadyB;
    logic [7:0]  inDataB;
    logic        outValidB;
    logic        outReadyB;
    logic [7:0]  outDataB;
    logic [1:0]  occupancyB;

    int testsRun;
    int testsFailed;

    logic [7:0] qB[$];
    bit         accB;
    bit         consB;

    skid_register #(
        .WIDTH       (32),
        .RESET_VALUE (32'hDEAD_BEEF)
    ) dutA (
        .clock      (clock),
        .clr        (clrA),
        .ctrl_flush (ctrlFlushA),
        .in_valid   (inValidA),
        .in_ready   (inReadyA),
        .in_data    (inDataA),
        .out_valid  (outValidA),
        .out_ready  (outReadyA),
        .out_data   (outDataA),
        .occupancy  (occupancyA)
    );

    skid_register #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dutB (
        .clock      (clock),
        .clr        (clrB),
        .ctrl_flush (ctrlFlushB),
        .in_valid   (inValidB),
        .in_ready   (inReadyB),
        .in_data    (inDataB),
        .out_valid  (outValidB),
        .out_ready  (outReadyB),
        .out_data   (outDataB),
        .occupancy  (occupancyB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference for the random instance: a FIFO of held words with capacity
    // two; the upstream sees room only if fewer than two words were held.
    always @(posedge clock) begin
        if (clrB) begin
            qB.delete();
        end else begin
            accB  = inValidB && (qB.size() < 2);
            consB = outReadyB && (qB.size() > 0);
            if (ctrlFlushB) begin
                qB.delete();
            end else begin
                if (consB) void'(qB.pop_front());
                if (accB) qB.push_back(inDataB);
            end
        end
    end

    task automatic stepA();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clrA = 1'b1;
        inValidA = 1'b1;
        inDataA = 32'h1234_5678;
        outReadyA = 1'b1;
        stepA();
        stepA();
        testsRun += 4;
        if (inReadyA !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL reset inReady: got %0b want 1", inReadyA);
        end
        if (outValidA !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset outValid: got %0b want 0", outValidA);
        end
        if (outDataA !== 32'hDEAD_BEEF) begin
            testsFailed++; $display("[TB] FAIL reset outData: got %h want deadbeef", outDataA);
        end
        if (occupancyA !== 2'd0) begin
            testsFailed++; $display("[TB] FAIL reset occupancy: got %0d want 0", occupancyA);
        end
        clrA = 1'b0;
        inValidA = 1'b0;
    endtask

    task automatic test_streaming();
        outReadyA = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            inValidA = 1'b1;
            inDataA = 32'(i);
            stepA();
            testsRun += 4;
            if (outValidA !== 1'b1) begin
                testsFailed++; $display("[TB] FAIL stream outValid[%0d]: got %0b want 1", i, outValidA);
            end
            if (outDataA !== 32'(i)) begin
                testsFailed++; $display("[TB] FAIL stream outData[%0d]: got %h want %h", i, outDataA, 32'(i));
            end
            if (occupancyA !== 2'd1) begin
                testsFailed++; $display("[TB] FAIL stream occupancy[%0d]: got %0d want 1", i, occupancyA);
            end
            if (inReadyA !== 1'b1) begin
                testsFailed++; $display("[TB] FAIL stream inReady[%0d]: got %0b want 1", i, inReadyA);
            end
        end
        inValidA = 1'b0;
        stepA();
        testsRun++;
        if (outValidA !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL stream drain outValid: got %0b want 0", outValidA);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] expData[6];
        logic [1:0]  expOcc[6];
        logic        expReady[6];
        expData  = '{32'hA, 32'hA, 32'hA, 32'hA, 32'hB, 32'hC};
        expOcc   = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        expReady = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        outReadyA = 1'b0;
        inValidA = 1'b1;
        for (int i = 0; i < 6; i++) begin
            inDataA = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hC;
            outReadyA = (i >= 4);
            stepA();
            testsRun += 3;
            if (outDataA !== expData[i]) begin
                testsFailed++; $display("[TB] FAIL backpressure outData[%0d]: got %h want %h", i, outDataA, expData[i]);
            end
            if (occupancyA !== expOcc[i]) begin
                testsFailed++; $display("[TB] FAIL backpressure occupancy[%0d]: got %0d want %0d", i, occupancyA, expOcc[i]);
            end
            if (inReadyA !== expReady[i]) begin
                testsFailed++; $display("[TB] FAIL backpressure inReady[%0d]: got %0b want %0b", i, inReadyA, expReady[i]);
            end
        end
        inValidA = 1'b0;
        stepA();
        testsRun++;
        if (outValidA !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL backpressure drain outValid: got %0b want 0", outValidA);
        end
    endtask

    task automatic test_flush();
        outReadyA = 1'b0;
        inValidA = 1'b1;
        inDataA = 32'h11;
        stepA();
        inDataA = 32'h22;
        stepA();
        ctrlFlushA = 1'b1;
        inDataA = 32'h55;
        stepA();
        testsRun += 3;
        if (outValidA !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL flush outValid: got %0b want 0", outValidA);
        end
        if (occupancyA !== 2'd0) begin
            testsFailed++; $display("[TB] FAIL flush occupancy: got %0d want 0", occupancyA);
        end
        if (inReadyA !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL flush inReady: got %0b want 1", inReadyA);
        end
        ctrlFlushA = 1'b0;
        inValidA = 1'b0;
        outReadyA = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepA();
            testsRun++;
            if (outValidA !== 1'b0) begin
                testsFailed++; $display("[TB] FAIL flush leak outValid[%0d]: got %0b data %h want 0", i, outValidA, outDataA);
            end
        end
        // A word that would be accepted in EMPTY is dropped by flush and the
        // main register keeps its previous word.
        ctrlFlushA = 1'b1;
        inValidA = 1'b1;
        inDataA = 32'h66;
        stepA();
        testsRun += 2;
        if (outValidA !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL flush drop outValid: got %0b want 0", outValidA);
        end
        if (outDataA !== 32'h11) begin
            testsFailed++; $display("[TB] FAIL flush keep outData: got %h want 11", outDataA);
        end
        ctrlFlushA = 1'b0;
        inDataA = 32'h99;
        outReadyA = 1'b0;
        stepA();
        testsRun += 2;
        if (outValidA !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL post-flush outValid: got %0b want 1", outValidA);
        end
        if (outDataA !== 32'h99) begin
            testsFailed++; $display("[TB] FAIL post-flush outData: got %h want 99", outDataA);
        end
        inValidA = 1'b0;
        outReadyA = 1'b1;
        stepA();
    endtask

    task automatic test_clr_flush();
        outReadyA = 1'b0;
        inValidA = 1'b1;
        inDataA = 32'h31;
        stepA();
        inDataA = 32'h32;
        stepA();
        clrA = 1'b1;
        ctrlFlushA = 1'b1;
        inDataA = 32'h33;
        outReadyA = 1'b1;
        stepA();
        testsRun += 4;
        if (outValidA !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL clr outValid: got %0b want 0", outValidA);
        end
        if (outDataA !== 32'hDEAD_BEEF) begin
            testsFailed++; $display("[TB] FAIL clr outData: got %h want deadbeef", outDataA);
        end
        if (occupancyA !== 2'd0) begin
            testsFailed++; $display("[TB] FAIL clr occupancy: got %0d want 0", occupancyA);
        end
        if (inReadyA !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL clr inReady: got %0b want 1", inReadyA);
        end
        clrA = 1'b0;
        ctrlFlushA = 1'b0;
        inDataA = 32'h77;
        stepA();
        testsRun += 3;
        if (outValidA !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL post-clr outValid: got %0b want 1", outValidA);
        end
        if (outDataA !== 32'h77) begin
            testsFailed++; $display("[TB] FAIL post-clr outData: got %h want 77", outDataA);
        end
        if (occupancyA !== 2'd1) begin
            testsFailed++; $display("[TB] FAIL post-clr occupancy: got %0d want 1", occupancyA);
        end
        inValidA = 1'b0;
        stepA();
    endtask

    task automatic test_random();
        logic       stallNow;
        logic [7:0] dataNow;
        int         delivered;
        delivered = 0;
        clrB = 1'b1;
        stepA();
        stepA();
        clrB = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            inValidB   = 1'($urandom_range(0, 1));
            outReadyB  = 1'($urandom_range(0, 1));
            inDataB    = 8'($urandom);
            ctrlFlushB = ($urandom_range(0, 99) == 0);
            stallNow   = outValidB && !outReadyB;
            dataNow    = outDataB;
            if (outValidB && outReadyB && !ctrlFlushB) delivered++;
            stepA();
            testsRun += 4;
            if (outValidB !== (qB.size() != 0)) begin
                testsFailed++; $display("[TB] FAIL random outValid@%0d: got %0b want %0b", c, outValidB, qB.size() != 0);
            end
            if (occupancyB !== 2'(qB.size())) begin
                testsFailed++; $display("[TB] FAIL random occupancy@%0d: got %0d want %0d", c, occupancyB, qB.size());
            end
            if (inReadyB !== (qB.size() < 2)) begin
                testsFailed++; $display("[TB] FAIL random inReady@%0d: got %0b want %0b", c, inReadyB, qB.size() < 2);
            end
            if (stallNow && outDataB !== dataNow) begin
                testsFailed++; $display("[TB] FAIL random stall@%0d: got %h want %h", c, outDataB, dataNow);
            end
            if (qB.size() > 0) begin
                testsRun++;
                if (outDataB !== qB[0]) begin
                    testsFailed++; $display("[TB] FAIL random order@%0d: got %h want %h", c, outDataB, qB[0]);
                end
            end
        end
        testsRun++;
        if (delivered < 1000) begin
            testsFailed++; $display("[TB] FAIL random traffic: got %0d words want at least 1000", delivered);
        end
        inValidB = 1'b0;
        ctrlFlushB = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        clrA = 1'b1; ctrlFlushA = 1'b0; inValidA = 1'b0; inDataA = '0; outReadyA = 1'b0;
        clrB = 1'b1; ctrlFlushB = 1'b0; inValidB = 1'b0; inDataB = '0; outReadyB = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_clr_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/skid_register.md
# skid_register

Parametrised pipeline register with a ready/valid handshake and a one-entry skid buffer. It is the successor to the fixed 32-bit enable register, for use between processor pipeline stages. It accepts a word whenever it is ready, holds it stable under backpressure, and supports a flush that drops all in-flight contents. Full throughput is one word per cycle with one cycle of latency, and `in_ready` depends only on internal state.

## Interface
- `WIDTH`, default 32: data width in bits, ≥1.
- `RESET_VALUE`, default 0: value loaded into both data registers on `clr`.
- `clock`, input, 1: rising-edge clock.
- `clr`, input, 1: synchronous, active-high reset.
- `ctrl_flush`, input, 1: synchronous drop of all held entries.
- `in_valid`, input, 1: upstream offers `in_data`.
- `in_ready`, output, 1: block can accept this cycle; registered.
- `in_data`, input, WIDTH: upstream word.
- `out_valid`, output, 1: `out_data` holds a valid word.
- `out_ready`, input, 1: downstream consumes this cycle.
- `out_data`, output, WIDTH: head word; driven from the main register.
- `occupancy`, output, 2: number of held entries, 0 to 2.

## Operation
- Storage is a main register (`main_data`, `main_v`) and a skid register (`skid_data`, `skid_v`).
- A transfer is accepted when `in_valid && in_ready`; a word is consumed when `out_valid && out_ready`.
- States, encoded by {`skid_v`, `main_v`}:
  - EMPTY: main not valid.
  - ONE: main valid, skid empty.
  - TWO: both valid.
- EMPTY: accept → ONE; main loads `in_data`.
- ONE:
  - Accept and consume → stay in ONE; main loads `in_data`.
  - Accept without consume → TWO; skid loads `in_data`.
  - Consume without accept → EMPTY.
  - Neither → hold.
- TWO: `in_ready` is 0, so no accept.
  - Consume → ONE; main loads `skid_data`, `skid_v` clears.
  - No consume → hold.
- Output signals:
  - `in_ready` = !`skid_v`.
  - `out_valid` = `main_v`.
  - `out_data` = `main_data`.
  - `occupancy` = `main_v` + `skid_v`.
- Order is preserved: a word is never overtaken or duplicated, and no accepted word is lost except by flush or `clr`.
- While `out_valid` && !`out_ready`, `out_data` must not change.
- Flush:
  - `ctrl_flush` high → next cycle `main_v` = `skid_v` = 0.
  - An input accepted in the same cycle is dropped.
  - Data registers keep their contents; only the valids clear.
- `clr`:
  - Next cycle both valids are 0 and both data registers equal `RESET_VALUE`.
  - `clr` has priority over `ctrl_flush` and over any handshake.

## Timing
- Reset values:
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_data` = `RESET_VALUE`
  - `occupancy` = 0
- Latency: a word accepted at edge N is visible on `out_data` with `out_valid` = 1 after edge N (cycle N+1).
- Throughput: with `out_ready` held at 1, one word per cycle is sustained indefinitely in state ONE.
- `in_ready` is a flop output. Upstream sees backpressure one cycle after the skid fills, which is why the skid entry exists.
- Simultaneous accept and consume in ONE is legal and keeps occupancy at 1.
- Asserting `clr` in any state, including mid-burst, takes effect at the next edge; handshake inputs in that cycle are ignored.
- The first cycle after `clr` or flush deasserts accepts normally.

## Structure
- Shared package `pipe_pkg` holds:
  - the localparams `OCC_EMPTY` = 2'd0, `OCC_ONE` = 2'd1, `OCC_TWO` = 2'd2;
  - the default width constant `WORD_WIDTH` = 32.
- Sub-module `regn` (`WIDTH`, `RESET_VALUE`): an enable register with synchronous clear. It is instantiated twice, for main and skid data.
- Valid bits and next-state logic live in `skid_register` itself.

## Test plan
- Reset: assert `clr` for 2 cycles with `RESET_VALUE` = 32'hDEAD_BEEF → `in_ready` = 1, `out_valid` = 0, `out_data` = 32'hDEAD_BEEF, `occupancy` = 0.
- Streaming: send 0x1, 0x2, … 0x10 on consecutive cycles with `out_ready` = 1 → output shows the same 16 words in order, each one cycle after acceptance; `occupancy` stays at 1 and no stall occurs.
- Backpressure: hold `out_ready` = 0 and send 0xA, 0xB, 0xC → 0xA and 0xB are accepted, `in_ready` drops after 0xB, and 0xC is held upstream with `occupancy` = 2. Release `out_ready` → output is 0xA, 0xB, 0xC in order, and `out_data` stays at 0xA during the stall.
- Flush in TWO while `in_valid` = 1 with 0x55 → next cycle `out_valid` = 0, `occupancy` = 0, `in_ready` = 1, and 0x55 never appears at the output.
- `clr` and `ctrl_flush` together mid-burst → `clr` result: valids are 0 and `out_data` = `RESET_VALUE`. A new word 0x77 sent the following cycle appears one cycle later.
- Randomised valid/ready at 50% for 10k cycles with WIDTH = 8, plus a scoreboard → no loss, duplication or reordering, and `out_data` is stable whenever stalled.
